// File: rtl/pipe_stage_reg.sv
// ----------------------------------------------------------------------------
// pipe_stage_reg : parametrised valid/ready pipeline register, optional skid
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pipe_stage_reg #(
   parameter int                DATA_W      = 128,
   parameter int                CTRL_W      = 24,
   parameter int                SKID        = 1,
   parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   input  logic              flush,
   input  logic              bubble,
   input  logic [CTRL_W-1:0] kill_mask,
   output logic [1:0]        occupancy
);

   logic              main_valid_q, main_valid_d;
   logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
   logic [DATA_W-1:0] main_data_q,  main_data_d;
   logic              skid_valid_q, skid_valid_d;
   logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
   logic [DATA_W-1:0] skid_data_q,  skid_data_d;
   logic [1:0]        occ_q,        occ_d;
   logic              in_xfer;
   logic              main_free;

   assign in_xfer   = in_valid && in_ready;
   assign main_free = !main_valid_q || out_ready;

   always_comb begin
      main_valid_d = main_valid_q;
      main_ctrl_d  = main_ctrl_q;
      main_data_d  = main_data_q;
      skid_valid_d = skid_valid_q;
      skid_ctrl_d  = skid_ctrl_q;
      skid_data_d  = skid_data_q;
      if (flush) begin
         main_valid_d = 1'b0;
         main_ctrl_d  = '0;
         skid_valid_d = 1'b0;
      end else begin
         // Skid drains first so an older entry is never overtaken.
         if (main_free) begin
            if (skid_valid_q) begin
               main_valid_d = 1'b1;
               main_ctrl_d  = skid_ctrl_q;
               main_data_d  = skid_data_q;
               skid_valid_d = 1'b0;
            end else if (bubble) begin
               main_valid_d = 1'b1;
               main_ctrl_d  = BUBBLE_CTRL;
            end else if (in_xfer) begin
               main_valid_d = 1'b1;
               main_ctrl_d  = in_ctrl;
               main_data_d  = in_data;
            end else begin
               main_valid_d = 1'b0;
            end
         end else if (in_xfer && (SKID != 0)) begin
            skid_valid_d = 1'b1;
            skid_ctrl_d  = in_ctrl;
            skid_data_d  = in_data;
         end
         main_ctrl_d = main_ctrl_d & ~kill_mask;
      end
      occ_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid_q <= 1'b0;
         main_ctrl_q  <= '0;
         main_data_q  <= '0;
         occ_q        <= 2'd0;
      end else begin
         main_valid_q <= main_valid_d;
         main_ctrl_q  <= main_ctrl_d;
         main_data_q  <= main_data_d;
         occ_q        <= occ_d;
      end
   end

   generate
      if (SKID != 0) begin : g_skid
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               skid_valid_q <= 1'b0;
               skid_ctrl_q  <= '0;
               skid_data_q  <= '0;
            end else begin
               skid_valid_q <= skid_valid_d;
               skid_ctrl_q  <= skid_ctrl_d;
               skid_data_q  <= skid_data_d;
            end
         end
         assign in_ready = !bubble && !skid_valid_q;
      end else begin : g_no_skid
         assign skid_valid_q = 1'b0;
         assign skid_ctrl_q  = '0;
         assign skid_data_q  = '0;
         assign in_ready     = !bubble && (!main_valid_q || out_ready);
      end
   endgenerate

   assign out_valid = main_valid_q;
   assign out_ctrl  = main_ctrl_q;
   assign out_data  = main_data_q;
   assign occupancy = occ_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: SKID=1 instance checked via queue
// and monitor, SKID=0 instance checked directly.
`default_nettype none

module tb_pipe_stage_reg;

   typedef struct {
      logic [23:0]  c;
      logic [127:0] d;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;

   logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
   logic [23:0]  in_ctrl = '0, out_ctrl, kill_mask = '0;
   logic [127:0] in_data = '0, out_data;
   logic         flush = 1'b0, bubble = 1'b0;
   logic [1:0]   occupancy;

   logic         in_valid0 = 1'b0, in_ready0, out_valid0, out_ready0 = 1'b0;
   logic [23:0]  in_ctrl0 = '0, out_ctrl0;
   logic [127:0] in_data0 = '0, out_data0;
   logic [1:0]   occupancy0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(128), .CTRL_W(24), .SKID(1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
      .flush(flush), .bubble(bubble), .kill_mask(kill_mask), .occupancy(occupancy)
   );

   pipe_stage_reg #(.DATA_W(128), .CTRL_W(24), .SKID(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid0), .in_ready(in_ready0), .in_ctrl(in_ctrl0), .in_data(in_data0),
      .out_valid(out_valid0), .out_ready(out_ready0), .out_ctrl(out_ctrl0), .out_data(out_data0),
      .flush(1'b0), .bubble(1'b0), .kill_mask(24'h0), .occupancy(occupancy0)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [23:0] c, input logic [127:0] d);
      exp_t e;
      e.c = c;
      e.d = d;
      sb.push_back(e);
   endtask

   // Monitor: every output transfer must match the oldest expected entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("sb_unexpected_output", {104'h0, out_ctrl}, 128'hDEAD);
            end else begin
               e = sb.pop_front();
               chk("sb_ctrl", {104'h0, out_ctrl}, {104'h0, e.c});
               chk("sb_data", out_data, e.d);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      step(); step();
      chk("rst_out_valid", {127'h0, out_valid}, 128'h0);
      chk("rst_occupancy", {126'h0, occupancy}, 128'h0);
      chk("rst_out_ctrl", {104'h0, out_ctrl}, 128'h0);
      chk("rst_out_data", out_data, 128'h0);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", {127'h0, in_ready}, 128'h1);
      chk("rst_in_ready0", {127'h0, in_ready0}, 128'h1);

      // Streaming with 1-cycle latency
      out_ready = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         in_valid = 1'b1;
         in_ctrl  = 24'(i);
         in_data  = 128'h1000 + 128'(i);
         push(24'(i), 128'h1000 + 128'(i));
         step();
         chk("stream_occ", {126'h0, occupancy}, 128'h1);
         chk("stream_out_ctrl", {104'h0, out_ctrl}, 128'(i));
      end
      in_valid = 1'b0;
      step();
      chk("stream_drain_valid", {127'h0, out_valid}, 128'h0);

      // Fill main + skid, then drain in order
      out_ready = 1'b0;
      in_valid = 1'b1; in_ctrl = 24'h00000A; in_data = 128'hA0;
      push(24'h00000A, 128'hA0);
      step();
      in_ctrl = 24'h00000B; in_data = 128'hB0;
      push(24'h00000B, 128'hB0);
      step();
      chk("full_occ", {126'h0, occupancy}, 128'h2);
      chk("full_in_ready", {127'h0, in_ready}, 128'h0);
      in_ctrl = 24'h00000C; in_data = 128'hC0;
      step();
      chk("full_ignored_occ", {126'h0, occupancy}, 128'h2);
      chk("full_hold_ctrl", {104'h0, out_ctrl}, 128'hA);
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      chk("drain_ctrl_b", {104'h0, out_ctrl}, 128'hB);
      chk("drain_in_ready", {127'h0, in_ready}, 128'h1);
      step();
      chk("drain_occ", {126'h0, occupancy}, 128'h0);

      // Bubble injection with data held
      out_ready = 1'b0;
      in_valid = 1'b1; in_ctrl = 24'hFFFFFF; in_data = 128'hABC;
      push(24'hFFFFFF, 128'hABC);
      step();
      in_valid = 1'b0;
      bubble = 1'b1;
      out_ready = 1'b1;
      push(24'h000000, 128'hABC);
      #1;
      chk("bubble_in_ready", {127'h0, in_ready}, 128'h0);
      step();
      bubble = 1'b0;
      chk("bubble_valid", {127'h0, out_valid}, 128'h1);
      chk("bubble_ctrl", {104'h0, out_ctrl}, 128'h0);
      chk("bubble_data", out_data, 128'hABC);
      step();
      chk("bubble_drain_occ", {126'h0, occupancy}, 128'h0);

      // Flush with two entries held and a simultaneous input
      out_ready = 1'b0;
      in_valid = 1'b1; in_ctrl = 24'h000011; in_data = 128'h111;
      step();
      in_ctrl = 24'h000022; in_data = 128'h222;
      step();
      chk("pre_flush_occ", {126'h0, occupancy}, 128'h2);
      flush = 1'b1;
      in_ctrl = 24'h000033; in_data = 128'h333;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_occ", {126'h0, occupancy}, 128'h0);
      chk("flush_valid", {127'h0, out_valid}, 128'h0);
      chk("flush_ctrl", {104'h0, out_ctrl}, 128'h0);
      chk("flush_data", out_data, 128'h111);
      out_ready = 1'b1;
      step();
      chk("flush_input_dropped", {127'h0, out_valid}, 128'h0);

      // kill_mask on a stalled entry and on a landing entry
      out_ready = 1'b0;
      in_valid = 1'b1; in_ctrl = 24'h00000F; in_data = 128'h5A5;
      step();
      in_valid = 1'b0;
      kill_mask = 24'h000004;
      step();
      kill_mask = 24'h0;
      chk("kill_ctrl", {104'h0, out_ctrl}, 128'hB);
      chk("kill_data", out_data, 128'h5A5);
      chk("kill_valid", {127'h0, out_valid}, 128'h1);
      push(24'h00000B, 128'h5A5);
      out_ready = 1'b1;
      in_valid = 1'b1; in_ctrl = 24'h0000F0; in_data = 128'hF0F;
      kill_mask = 24'h000010;
      push(24'h0000E0, 128'hF0F);
      step();
      in_valid = 1'b0;
      kill_mask = 24'h0;
      chk("kill_land_ctrl", {104'h0, out_ctrl}, 128'hE0);
      step();
      chk("kill_drain_occ", {126'h0, occupancy}, 128'h0);

      // SKID=0 combinational in_ready, then asynchronous reset mid-stall
      out_ready = 1'b0;
      in_valid = 1'b1; in_ctrl = 24'h000099; in_data = 128'h999;
      in_valid0 = 1'b1; in_ctrl0 = 24'h000077; in_data0 = 128'h7;
      step();
      in_valid = 1'b0;
      in_valid0 = 1'b0;
      chk("s0_valid", {127'h0, out_valid0}, 128'h1);
      chk("s0_ready_low", {127'h0, in_ready0}, 128'h0);
      out_ready0 = 1'b1;
      #1;
      chk("s0_ready_follow_hi", {127'h0, in_ready0}, 128'h1);
      out_ready0 = 1'b0;
      #1;
      chk("s0_ready_follow_lo", {127'h0, in_ready0}, 128'h0);
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid0", {127'h0, out_valid0}, 128'h0);
      chk("async_rst_ctrl0", {104'h0, out_ctrl0}, 128'h0);
      chk("async_rst_occ0", {126'h0, occupancy0}, 128'h0);
      chk("async_rst_occ", {126'h0, occupancy}, 128'h0);
      chk("async_rst_valid", {127'h0, out_valid}, 128'h0);
      chk("sb_empty", 128'(sb.size()), 128'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
